// File: rtl/gas_ctrl_pkg.sv
// Shared types and defaults for the gas alarm controller: state codes, level width, actuator decode.
// Pure declarations; no latency, no backpressure.
package gas_ctrl_pkg;

  localparam int LVL_W         = 3;
  localparam int WARN_LVL_DEF  = 3;
  localparam int ALARM_LVL_DEF = 5;

  typedef logic [LVL_W-1:0] lvl_t;

  typedef enum logic [1:0] {
    SAFE  = 2'd0,
    WARN  = 2'd1,
    ALARM = 2'd2,
    VENT  = 2'd3
  } gas_state_e;

  typedef struct packed {
    logic buzzer;
    logic fan_on;
    logic valve_close;
  } act_t;

  function automatic act_t decode_act(input gas_state_e s);
    act_t a;
    a = '0;
    case (s)
      WARN:    a = '{buzzer: 1'b0, fan_on: 1'b1, valve_close: 1'b0};
      ALARM:   a = '{buzzer: 1'b1, fan_on: 1'b1, valve_close: 1'b1};
      VENT:    a = '{buzzer: 1'b0, fan_on: 1'b1, valve_close: 1'b1};
      default: a = '0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/gas_level_max.sv
// Highest detector level across all rooms and its room index; ties resolve to the lowest index.
// Combinational, zero latency; no backpressure.
module gas_level_max
  import gas_ctrl_pkg::*;
#(
  parameter int N_ROOMS = 4,
  parameter int RW      = (N_ROOMS > 1) ? $clog2(N_ROOMS) : 1
) (
  input  logic [LVL_W*N_ROOMS-1:0] lvl,
  output logic [LVL_W-1:0]         max_lvl,
  output logic [RW-1:0]            max_room
);

  always_comb begin
    max_lvl  = '0;
    max_room = '0;
    // Strict greater-than keeps the earliest room on a tie.
    for (int i = 0; i < N_ROOMS; i++) begin
      if (lvl[LVL_W*i +: LVL_W] > max_lvl) begin
        max_lvl  = lvl[LVL_W*i +: LVL_W];
        max_room = RW'(i);
      end
    end
  end

endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm sequencer: registered room-level max feeds a SAFE/WARN/ALARM/VENT FSM driving actuators.
// Level change reaches max_lvl in 1 edge and state in 2 edges; no backpressure, ack is a level-sampled pulse.
module gas_alarm_controller
  import gas_ctrl_pkg::*;
#(
  parameter int  N_ROOMS   = 4,
  parameter int  WARN_LVL  = WARN_LVL_DEF,
  parameter int  ALARM_LVL = ALARM_LVL_DEF,
  parameter int  HOLD_CYC  = 16,
  localparam int RW        = (N_ROOMS > 1) ? $clog2(N_ROOMS) : 1
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [LVL_W*N_ROOMS-1:0] lvl,
  input  logic                     ack,
  output logic [1:0]               state,
  output logic [LVL_W-1:0]         max_lvl,
  output logic [RW-1:0]            max_room,
  output logic [RW-1:0]            alarm_room,
  output logic                     buzzer,
  output logic                     fan_on,
  output logic                     valve_close
);

  localparam int             CW       = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam lvl_t           WARN_L   = lvl_t'(WARN_LVL);
  localparam lvl_t           ALARM_L  = lvl_t'(ALARM_LVL);
  localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYC - 1);

  lvl_t          cmb_lvl;
  logic [RW-1:0] cmb_room;
  gas_state_e    st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          lvl_hi, lvl_mid;
  act_t          act;

  gas_level_max #(.N_ROOMS(N_ROOMS), .RW(RW)) u_max (
    .lvl      (lvl),
    .max_lvl  (cmb_lvl),
    .max_room (cmb_room)
  );

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      st         <= SAFE;
      max_lvl    <= '0;
      max_room   <= '0;
      alarm_room <= '0;
      cnt        <= '0;
    end else begin
      st       <= st_nxt;
      max_lvl  <= cmb_lvl;
      max_room <= cmb_room;
      cnt      <= cnt_nxt;
      // Latch the offending room only on entry, so it survives VENT and SAFE.
      if (st_nxt == ALARM && st != ALARM) alarm_room <= max_room;
    end
  end

  assign lvl_hi  = (max_lvl >= ALARM_L);
  assign lvl_mid = (max_lvl >= WARN_L);

  always_comb begin
    st_nxt  = st;
    cnt_nxt = '0;
    case (st)
      SAFE: begin
        if (lvl_hi)       st_nxt = ALARM;
        else if (lvl_mid) st_nxt = WARN;
      end
      WARN: begin
        if (lvl_hi)        st_nxt = ALARM;
        else if (!lvl_mid) st_nxt = SAFE;
      end
      ALARM: begin
        if (ack && !lvl_mid) st_nxt = VENT;
      end
      VENT: begin
        // Any non-clean sample restarts the hold window from zero.
        if (lvl_hi)               st_nxt = ALARM;
        else if (lvl_mid)         cnt_nxt = '0;
        else if (cnt == CNT_LAST) st_nxt = SAFE;
        else                      cnt_nxt = cnt + CW'(1);
      end
      default: st_nxt = SAFE;
    endcase
  end

  assign act         = decode_act(st);
  assign state       = st;
  assign buzzer      = act.buzzer;
  assign fan_on      = act.fan_on;
  assign valve_close = act.valve_close;

endmodule

// File: tb/tb_gas_alarm_controller.sv
// Directed bench for gas_alarm_controller: per-cycle comparison against a spec-level model plus literal checkpoints.
module tb_gas_alarm_controller;

  localparam int NR    = 4;
  localparam int W_LVL = 3;
  localparam int A_LVL = 5;
  localparam int HOLD  = 16;

  logic        clk = 1'b0;
  logic        arst;
  logic [11:0] lvl;
  logic        ack;
  logic [1:0]  state;
  logic [2:0]  max_lvl;
  logic [1:0]  max_room;
  logic [1:0]  alarm_room;
  logic        buzzer, fan_on, valve_close;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_state, m_max, m_room, m_aroom, m_clean;

  gas_alarm_controller dut (
    .clk         (clk),
    .arst        (arst),
    .lvl         (lvl),
    .ack         (ack),
    .state       (state),
    .max_lvl     (max_lvl),
    .max_room    (max_room),
    .alarm_room  (alarm_room),
    .buzzer      (buzzer),
    .fan_on      (fan_on),
    .valve_close (valve_close)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: state codes 0 SAFE, 1 WARN, 2 ALARM, 3 VENT; m_clean counts clean VENT samples.
  always @(posedge clk or negedge arst) begin : model
    int nmax, nroom, rl;
    if (!arst) begin
      m_state <= 0; m_max <= 0; m_room <= 0; m_aroom <= 0; m_clean <= 0;
    end else begin
      nmax = 0;
      for (int i = 0; i < NR; i++) begin
        rl = int'((lvl >> (3 * i)) & 12'h7);
        nmax = (rl > nmax) ? rl : nmax;
      end
      nroom = 0;
      for (int i = NR - 1; i >= 0; i--)
        if (int'((lvl >> (3 * i)) & 12'h7) == nmax) nroom = i;
      m_max  <= nmax;
      m_room <= nroom;
      if (m_state != 2 && m_max >= A_LVL) begin
        m_state <= 2;
        m_aroom <= m_room;
        m_clean <= 0;
      end else if (m_state == 0) begin
        if (m_max >= W_LVL) m_state <= 1;
      end else if (m_state == 1) begin
        if (m_max < W_LVL) m_state <= 0;
      end else if (m_state == 2) begin
        if (ack && m_max < W_LVL) begin
          m_state <= 3;
          m_clean <= 0;
        end
      end else begin
        if (m_max >= W_LVL) m_clean <= 0;
        else if (m_clean + 1 == HOLD) begin
          m_state <= 0;
          m_clean <= 0;
        end else m_clean <= m_clean + 1;
      end
    end
  end

  always @(posedge clk) begin : compare
    logic [11:0] exp_v, act_v;
    #1;
    if (chk_en) begin
      exp_v = {2'(m_state), 3'(m_max), 2'(m_room), 2'(m_aroom),
               1'(m_state == 2), 1'(m_state != 0), 1'(m_state >= 2)};
      act_v = {state, max_lvl, max_room, alarm_room, buzzer, fan_on, valve_close};
      chk("cycle_model", 32'(act_v), 32'(exp_v));
    end
  end

  initial begin
    lvl  = '0;
    ack  = 1'b0;
    arst = 1'b0;
    cyc(2);
    chk_en = 1'b1;
    chk("in_reset_state", 32'(state), 0);
    chk("in_reset_act", 32'({buzzer, fan_on, valve_close}), 0);
    arst = 1'b1;

    cyc(10);
    chk("idle_state", 32'(state), 0);
    chk("idle_act", 32'({buzzer, fan_on, valve_close}), 0);
    chk("idle_max", 32'(max_lvl), 0);

    lvl = 12'h0C0;
    cyc(1);
    chk("warn_max", 32'(max_lvl), 3);
    chk("warn_room", 32'(max_room), 2);
    chk("warn_not_yet", 32'(state), 0);
    cyc(1);
    chk("warn_state", 32'(state), 1);
    chk("warn_act", 32'({buzzer, fan_on, valve_close}), 3'b010);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("warn_ack_ignored", 32'(state), 1);
    lvl = '0;
    cyc(1);
    chk("warn_hold_one", 32'(state), 1);
    cyc(1);
    chk("warn_to_safe", 32'(state), 0);

    lvl = 12'hC30;
    cyc(1);
    chk("tie_max", 32'(max_lvl), 6);
    chk("tie_room", 32'(max_room), 1);
    cyc(1);
    chk("alarm_state", 32'(state), 2);
    chk("alarm_room1", 32'(alarm_room), 1);
    chk("alarm_act", 32'({buzzer, fan_on, valve_close}), 3'b111);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
    chk("alarm_ack_high_lvl", 32'(state), 2);
    lvl = '0;
    cyc(3);
    chk("alarm_ack_forgotten", 32'(state), 2);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("vent_state", 32'(state), 3);
    chk("vent_act", 32'({buzzer, fan_on, valve_close}), 3'b011);
    cyc(15);
    chk("vent_15_clean", 32'(state), 3);
    cyc(1);
    chk("vent_16_safe", 32'(state), 0);
    chk("aroom_hold_safe", 32'(alarm_room), 1);

    lvl = 12'hC00;
    cyc(2);
    chk("alarm2_room3", 32'(alarm_room), 3);
    lvl = '0;
    cyc(1);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("vent2_state", 32'(state), 3);
    cyc(10);
    lvl = 12'h004;
    cyc(1);
    chk("vent_inject_max", 32'(max_lvl), 4);
    lvl = '0;
    cyc(1);
    chk("vent_inject_stay", 32'(state), 3);
    cyc(15);
    chk("vent_restart_15", 32'(state), 3);
    cyc(1);
    chk("vent_restart_safe", 32'(state), 0);
    chk("aroom_hold_3", 32'(alarm_room), 3);

    lvl = 12'h180;
    cyc(2);
    chk("alarm3_room2", 32'(alarm_room), 2);
    lvl = '0;
    cyc(1);
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    chk("vent3_state", 32'(state), 3);
    lvl = 12'h007;
    cyc(2);
    chk("vent_realarm", 32'(state), 2);
    chk("vent_realarm_room0", 32'(alarm_room), 0);

    lvl = 12'h030;
    cyc(2);
    chk("pre_reset_alarm", 32'(state), 2);
    @(posedge clk);
    #2 arst = 1'b0;
    #1;
    chk("async_state", 32'(state), 0);
    chk("async_act", 32'({buzzer, fan_on, valve_close}), 0);
    chk("async_max", 32'(max_lvl), 0);
    #1 arst = 1'b1;
    @(negedge clk);
    cyc(1);
    chk("post_rst_safe", 32'(state), 0);
    chk("post_rst_max", 32'(max_lvl), 6);
    cyc(1);
    chk("post_rst_alarm", 32'(state), 2);
    chk("post_rst_room1", 32'(alarm_room), 1);

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
